// File: rtl/bmu_pkg.sv
// Shared sizing helpers and label conventions for the soft-decision branch metric unit.
// Label index bit i is the expected value of coded bit i.
package bmu_pkg;

    function automatic int bmu_metric_width(input int n, input int q);
        return $clog2(n * ((1 << q) - 1) + 1);
    endfunction

    function automatic int bmu_num_labels(input int n);
        return 1 << n;
    endfunction

    function automatic logic label_bit(input int label, input int i);
        return 1'((label >> i) & 1);
    endfunction

endpackage

// File: rtl/bmu_label_metric.sv
// Distance between one received soft symbol and one fixed branch label.
// Purely combinational; the caller registers the result.
module bmu_label_metric
    import bmu_pkg::*;
#(
    parameter int N     = 2,
    parameter int Q     = 3,
    parameter int MW    = bmu_metric_width(N, Q),
    parameter int LABEL = 0
) (
    input  logic [N*Q-1:0] sym,
    output logic [MW-1:0]  metric
);

    localparam logic [Q-1:0] SMAX = '1;

    // An expected '1' costs the distance from the strongest '1'; an expected '0' costs the raw value.
    always_comb begin
        metric = '0;
        for (int i = 0; i < N; i++) begin
            if (label_bit(LABEL, i)) begin
                metric = metric + MW'(SMAX - sym[i*Q +: Q]);
            end else begin
                metric = metric + MW'(sym[i*Q +: Q]);
            end
        end
    end

endmodule

// File: rtl/bmu_soft_pipe.sv
// Two-stage elastic branch metric unit: all 2^N label metrics per accepted symbol, one symbol per cycle.
// Stage 1 holds the raw symbol and frame index; stage 2 holds the metrics; refresh flushes both.
module bmu_soft_pipe
    import bmu_pkg::*;
#(
    parameter int N         = 2,
    parameter int Q         = 3,
    parameter int FRAME_LEN = 64,
    localparam int MW       = bmu_metric_width(N, Q),
    localparam int IW       = $clog2(FRAME_LEN),
    localparam int NL       = bmu_num_labels(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             refresh,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N*Q-1:0]   sym_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NL*MW-1:0] bm_out,
    output logic [IW-1:0]    sym_idx,
    output logic             first_sym,
    output logic             last_sym
);

    localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);

    logic             s1_v;
    logic [N*Q-1:0]   s1_sym;
    logic [IW-1:0]    s1_idx;
    logic             s1_first;
    logic             s1_last;
    logic [IW-1:0]    cnt;
    logic [NL*MW-1:0] bm_next;
    logic             s2_load;
    logic             s1_adv;
    logic             accept;

    assign s2_load  = !out_valid || out_ready;
    assign s1_adv   = !s1_v || s2_load;
    assign in_ready = s1_adv && !refresh;
    assign accept   = in_valid && in_ready;

    for (genvar j = 0; j < NL; j++) begin : g_lbl
        bmu_label_metric #(
            .N    (N),
            .Q    (Q),
            .MW   (MW),
            .LABEL(j)
        ) u_lbl (
            .sym   (s1_sym),
            .metric(bm_next[j*MW +: MW])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_v      <= 1'b0;
            s1_sym    <= '0;
            s1_idx    <= '0;
            s1_first  <= 1'b0;
            s1_last   <= 1'b0;
            cnt       <= '0;
            out_valid <= 1'b0;
            bm_out    <= '0;
            sym_idx   <= '0;
            first_sym <= 1'b0;
            last_sym  <= 1'b0;
        end else if (refresh) begin
            s1_v      <= 1'b0;
            out_valid <= 1'b0;
            cnt       <= '0;
        end else begin
            if (s1_adv) begin
                s1_v <= accept;
            end
            if (accept) begin
                s1_sym   <= sym_in;
                s1_idx   <= cnt;
                s1_first <= (cnt == '0);
                s1_last  <= (cnt == LAST_IDX);
                cnt      <= (cnt == LAST_IDX) ? '0 : cnt + 1'b1;
            end
            // Data registers only move with a live stage-1 entry so a stall keeps outputs frozen.
            if (s2_load) begin
                out_valid <= s1_v;
                if (s1_v) begin
                    bm_out    <= bm_next;
                    sym_idx   <= s1_idx;
                    first_sym <= s1_first;
                    last_sym  <= s1_last;
                end
            end
        end
    end

endmodule

// File: tb/tb_bmu_soft_pipe.sv
// Scoreboard bench: a soft-decision instance (N=2,Q=3,FRAME_LEN=4) and a hard-decision one (N=2,Q=1).
module tb_bmu_soft_pipe;

    typedef struct {
        logic [15:0] bm;
        logic [1:0]  idx;
        logic        first;
        logic        last;
    } exp_a_t;

    typedef struct {
        logic [7:0] bm;
        logic [5:0] idx;
        logic       first;
        logic       last;
    } exp_b_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        refresh = 1'b0;

    logic        in_valid_a = 1'b0;
    logic        in_ready_a;
    logic [5:0]  sym_in_a = '0;
    logic        out_valid_a;
    logic        out_ready_a = 1'b1;
    logic [15:0] bm_out_a;
    logic [1:0]  sym_idx_a;
    logic        first_a;
    logic        last_a;

    logic        in_valid_b = 1'b0;
    logic        in_ready_b;
    logic [1:0]  sym_in_b = '0;
    logic        out_valid_b;
    logic        out_ready_b = 1'b1;
    logic [7:0]  bm_out_b;
    logic [5:0]  sym_idx_b;
    logic        first_b;
    logic        last_b;

    int total = 0;
    int bad = 0;
    exp_a_t qa[$];
    exp_b_t qb[$];

    always #5 clk = ~clk;

    bmu_soft_pipe #(.N(2), .Q(3), .FRAME_LEN(4)) dut_a (
        .clk(clk), .rst(rst), .refresh(refresh),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .sym_in(sym_in_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .bm_out(bm_out_a),
        .sym_idx(sym_idx_a), .first_sym(first_a), .last_sym(last_a)
    );

    bmu_soft_pipe #(.N(2), .Q(1), .FRAME_LEN(64)) dut_b (
        .clk(clk), .rst(rst), .refresh(refresh),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .sym_in(sym_in_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .bm_out(bm_out_b),
        .sym_idx(sym_idx_b), .first_sym(first_b), .last_sym(last_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Outputs are sampled on the falling edge; a transfer happens at the next rising edge.
    always @(negedge clk) begin
        if (rst && !refresh && out_valid_a && out_ready_a) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_output", 32'd1, 32'd0);
            end else begin
                exp_a_t e;
                e = qa.pop_front();
                chk("a_bm", 32'(bm_out_a), 32'(e.bm));
                chk("a_idx", 32'(sym_idx_a), 32'(e.idx));
                chk("a_first", 32'(first_a), 32'(e.first));
                chk("a_last", 32'(last_a), 32'(e.last));
            end
        end
        if (rst && !refresh && out_valid_b && out_ready_b) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_output", 32'd1, 32'd0);
            end else begin
                exp_b_t e;
                e = qb.pop_front();
                chk("b_bm", 32'(bm_out_b), 32'(e.bm));
                chk("b_idx", 32'(sym_idx_b), 32'(e.idx));
                chk("b_first", 32'(first_b), 32'(e.first));
                chk("b_last", 32'(last_b), 32'(e.last));
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_a(input logic [5:0] s, input logic [15:0] bm, input logic [1:0] idx,
                          input logic f, input logic l, input bit track);
        int w;
        exp_a_t e;
        w = 0;
        in_valid_a = 1'b1;
        sym_in_a = s;
        #0;
        while (!in_ready_a && w < 50) begin
            tick(1);
            w++;
        end
        if (!in_ready_a) begin
            chk("a_send_timeout", 32'd0, 32'd1);
        end else if (track) begin
            e.bm = bm; e.idx = idx; e.first = f; e.last = l;
            qa.push_back(e);
        end
        tick(1);
        in_valid_a = 1'b0;
    endtask

    task automatic send_b(input logic [1:0] s, input logic [7:0] bm, input logic [5:0] idx,
                          input logic f, input logic l);
        int w;
        exp_b_t e;
        w = 0;
        in_valid_b = 1'b1;
        sym_in_b = s;
        #0;
        while (!in_ready_b && w < 50) begin
            tick(1);
            w++;
        end
        if (!in_ready_b) begin
            chk("b_send_timeout", 32'd0, 32'd1);
        end else begin
            e.bm = bm; e.idx = idx; e.first = f; e.last = l;
            qb.push_back(e);
        end
        tick(1);
        in_valid_b = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic [5:0]  st_sym [3];
        logic [15:0] st_bm  [3];
        logic [1:0]  st_idx [3];
        int acc;
        int vi;

        // Reset held for three cycles
        tick(3);
        chk("rst_out_valid_a", 32'(out_valid_a), 32'd0);
        chk("rst_bm_a", 32'(bm_out_a), 32'd0);
        chk("rst_idx_a", 32'(sym_idx_a), 32'd0);
        chk("rst_out_valid_b", 32'(out_valid_b), 32'd0);
        rst = 1'b1;
        tick(1);
        chk("rst_in_ready_a", 32'(in_ready_a), 32'd1);
        chk("rst_in_ready_b", 32'(in_ready_b), 32'd1);

        // Hard-decision stream, back to back
        send_b(2'b00, {2'd2, 2'd1, 2'd1, 2'd0}, 6'd0, 1'b1, 1'b0);
        send_b(2'b01, {2'd1, 2'd2, 2'd0, 2'd1}, 6'd1, 1'b0, 1'b0);
        chk("b_first_valid_latency", 32'(out_valid_b), 32'd1);
        send_b(2'b11, {2'd0, 2'd1, 2'd1, 2'd2}, 6'd2, 1'b0, 1'b0);
        tick(4);
        chk("b_drained", 32'(qb.size()), 32'd0);

        // First soft symbol and its latency
        send_a(6'b111_000, {4'd7, 4'd0, 4'd14, 4'd7}, 2'd0, 1'b1, 1'b0, 1'b1);
        chk("a_latency_not_yet", 32'(out_valid_a), 32'd0);
        tick(1);
        chk("a_latency_valid", 32'(out_valid_a), 32'd1);
        tick(3);

        // Frame wrap over four-symbol frame
        send_a({3'd3, 3'd5}, {4'd6, 4'd9, 4'd5, 4'd8}, 2'd1, 1'b0, 1'b0, 1'b1);
        send_a({3'd0, 3'd0}, {4'd14, 4'd7, 4'd7, 4'd0}, 2'd2, 1'b0, 1'b0, 1'b1);
        send_a({3'd7, 3'd7}, {4'd0, 4'd7, 4'd7, 4'd14}, 2'd3, 1'b0, 1'b1, 1'b1);
        send_a({3'd1, 3'd6}, {4'd7, 4'd12, 4'd2, 4'd7}, 2'd0, 1'b1, 1'b0, 1'b1);
        tick(4);
        chk("a_wrap_drained", 32'(qa.size()), 32'd0);

        // Downstream stall with continuous input
        st_sym[0] = {3'd4, 3'd2}; st_bm[0] = {4'd8, 4'd5, 4'd9, 4'd6}; st_idx[0] = 2'd1;
        st_sym[1] = 6'b111_000;   st_bm[1] = {4'd7, 4'd0, 4'd14, 4'd7}; st_idx[1] = 2'd2;
        st_sym[2] = {3'd0, 3'd0}; st_bm[2] = {4'd14, 4'd7, 4'd7, 4'd0}; st_idx[2] = 2'd3;
        out_ready_a = 1'b0;
        acc = 0;
        vi = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid_a = 1'b1;
            sym_in_a = st_sym[vi];
            #0;
            if (c >= 2) chk("stall_hold_bm", 32'(bm_out_a), 32'(st_bm[0]));
            if (in_ready_a) begin
                exp_a_t e;
                e.bm = st_bm[vi]; e.idx = st_idx[vi]; e.first = 1'b0; e.last = (st_idx[vi] == 2'd3);
                qa.push_back(e);
                acc++;
                if (vi < 2) vi++;
            end
            tick(1);
        end
        in_valid_a = 1'b0;
        chk("stall_accepts", 32'(acc), 32'd2);
        chk("stall_in_ready", 32'(in_ready_a), 32'd0);
        chk("stall_idx", 32'(sym_idx_a), 32'd1);
        out_ready_a = 1'b1;
        tick(4);
        chk("stall_drained", 32'(qa.size()), 32'd0);

        // Refresh with two symbols in flight
        out_ready_a = 1'b0;
        send_a(6'b000_001, '0, 2'd0, 1'b0, 1'b0, 1'b0);
        send_a(6'b000_010, '0, 2'd0, 1'b0, 1'b0, 1'b0);
        refresh = 1'b1;
        #1;
        chk("refresh_in_ready", 32'(in_ready_a), 32'd0);
        tick(1);
        refresh = 1'b0;
        chk("refresh_out_valid", 32'(out_valid_a), 32'd0);
        out_ready_a = 1'b1;
        send_a({3'd0, 3'd0}, {4'd14, 4'd7, 4'd7, 4'd0}, 2'd0, 1'b1, 1'b0, 1'b1);
        tick(4);
        chk("refresh_drained", 32'(qa.size()), 32'd0);

        // Asynchronous reset while stalled
        out_ready_a = 1'b0;
        send_a(6'b000_011, '0, 2'd0, 1'b0, 1'b0, 1'b0);
        send_a(6'b000_100, '0, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("pre_reset_valid", 32'(out_valid_a), 32'd1);
        rst = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid_a), 32'd0);
        chk("async_rst_bm", 32'(bm_out_a), 32'd0);
        chk("async_rst_idx", 32'(sym_idx_a), 32'd0);
        chk("async_rst_first", 32'(first_a), 32'd0);
        tick(1);
        rst = 1'b1;
        tick(1);
        out_ready_a = 1'b1;
        send_a({3'd7, 3'd7}, {4'd0, 4'd7, 4'd7, 4'd14}, 2'd0, 1'b1, 1'b0, 1'b1);
        tick(4);
        chk("post_reset_drained", 32'(qa.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
